rr_req_grant_arbiter: RTL and testbench
=======================================

Name: rr_req_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource between N requesters using a level req/grant handshake.
- Each grant is held while the owner keeps its request asserted.
- The grant is forcibly rotated after MAX_HOLD cycles if another requester is waiting, bounding latency.
- Sits between the requesting agents and the shared resource. Grant outputs are registered and drive the resource select directly.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps grant while others wait (>=1).
- IDW, $clog2(N), width of grant_id (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  level request per requester; bit i = requester i.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  OR of grant.
- grant_id  output  IDW  index of current owner; 0 when grant_valid=0.
- preempt  output  1  one-cycle pulse in the cycle a grant was taken by MAX_HOLD expiry.
- hold_cnt  output  $clog2(MAX_HOLD+1)  cycles the current owner has held grant, saturating at MAX_HOLD.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, grant=0, grant_valid=0, grant_id=0, preempt=0, hold_cnt=0, last_id=N-1 (so requester 0 wins first). Reset overrides everything, including mid-grant; the grant drops the cycle after the reset edge.
- Round-robin pick: scan indices last_id+1, last_id+2, ... mod N; the first with req=1 wins. The "other" pick is the same scan with the current owner excluded. last_id is updated to the winner on every new grant.
- State IDLE:
  - grant=0.
  - At posedge with |req=1: grant<=onehot(winner), grant_id<=winner, hold_cnt<=1, go to GRANT.
  - Latency: req high at edge k gives grant high after edge k (visible in cycle k..k+1). Never same-cycle combinational.
- State GRANT, owner o, evaluated at each posedge in priority order:
  1. req[o]=0 (release):
     - If another req is pending, hand off directly to the next RR winner: no idle gap, hold_cnt<=1, preempt<=0.
     - Otherwise grant<=0, hold_cnt<=0, go to IDLE.
  2. req[o]=1, hold_cnt==MAX_HOLD, other req pending: grant<=onehot(other winner), hold_cnt<=1, preempt<=1 for exactly one cycle.
  3. req[o]=1, any other case: keep grant; hold_cnt<=min(hold_cnt+1, MAX_HOLD); preempt<=0.
- A preempted requester that still holds req is re-granted only when its turn comes up again.
- Invariants:
  - grant is always one-hot or zero.
  - grant changes only at posedge.
  - grant[i]=1 implies req[i] was 1 at the preceding edge.
- Simultaneous requests in IDLE: lowest index after last_id wins, with wrap-around at N-1 → 0.
- Requests that drop before being granted are not remembered; there is no queuing.
- MAX_HOLD=1: rotation occurs every cycle whenever more than one requester is active.
- Starvation bound: any continuously asserted req is granted within (N-1)*MAX_HOLD+1 cycles.

Test Plan:
- Reset/single: rst for 2 cycles, then req=0001 held → grant=0001 one cycle after the first sampled req; grant_id=0; hold_cnt counts 1..8 and saturates at 8; preempt never pulses. Drop req → grant=0 next cycle.
- Simultaneous: from reset, req=1111 held with MAX_HOLD=8 → grants rotate 0001 (8 cycles), 0010, 0100, 1000, then 0001 again. preempt pulses at each handoff; grant is never zero between owners.
- Handoff on release: owner 1 holds, req[3] pending; drop req[1] at cycle 3 of hold → grant=1000 at the next edge, no gap, preempt=0, hold_cnt=1.
- Wrap-around/priority: last_id=3 (requester 3 just served), req=1010 → requester 1 wins, not 3.
- Reset mid-operation: assert rst while grant=0100, hold_cnt=5 → next cycle all outputs 0 and last_id=N-1. After rst drops with req=0110 → grant=0010.
- Assertions bound in the bench: one-hot-or-zero grant; grant[i] implies past req[i]; preempt only when previous hold_cnt==MAX_HOLD; every continuously held req is granted within (N-1)*MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/rr_req_grant_arbiter.sv
// rr_req_grant_arbiter
//   Round-robin arbiter that shares one resource between N requesters using a
//   level req/grant handshake. An owner keeps the grant while it holds its
//   request. If another requester is waiting, the grant is taken from the
//   owner after MAX_HOLD consecutive cycles, which bounds the waiting latency.
//   Every output comes from a register, so the outputs can drive the resource
//   select directly.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[N]       level request per requester (bit i = requester i)
//   grant[N]     registered one-hot grant, or all zero
//   grant_valid  OR of grant
//   grant_id     index of the current owner, 0 when no grant is active
//   preempt      one-cycle pulse in the cycle a grant was taken by hold expiry
//   hold_cnt     cycles the current owner has held the grant, saturates at MAX_HOLD
module rr_req_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N),
  localparam int HCW     = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt,
  output logic [HCW-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

  // Round-robin scan starting at last+1. The loop runs from the farthest
  // candidate to the nearest, so the nearest requester overrides the others.
  // The result is {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r,
                                           input logic [IDW-1:0] last);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx_v;
    int             idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx   = (int'(last) + k) % N;
      idx_v = IDW'(idx);
      if (r[idx_v]) begin
        res = {1'b1, idx_v};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           preempt_q, preempt_d;

  logic [IDW:0]   pick_all;
  logic [IDW:0]   pick_oth;
  logic           owner_req;

  // last_q always equals the current owner while a grant is active, so the
  // scan that excludes the owner visits the owner's successors first.
  assign pick_all  = rr_pick(req, last_q);
  assign pick_oth  = rr_pick(req & ~grant_q, last_q);
  assign owner_req = req[grant_id_q];

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= LAST_RST;
      hold_q     <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      preempt_q  <= preempt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_all[IDW]) state_d = S_GRANT;
        else               state_d = S_IDLE;
      end
      S_GRANT: begin
        if (!owner_req && !pick_oth[IDW]) state_d = S_IDLE;
        else                              state_d = S_GRANT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. It computes the next values of the registered outputs.
  always_comb begin
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    hold_d     = hold_q;
    preempt_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_all[IDW]) begin
          grant_d    = onehot(pick_all[IDW-1:0]);
          grant_id_d = pick_all[IDW-1:0];
          last_d     = pick_all[IDW-1:0];
          hold_d     = HOLD_ONE;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          hold_d     = '0;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          // The owner released. Hand off directly if someone is waiting, so no idle gap.
          if (pick_oth[IDW]) begin
            grant_d    = onehot(pick_oth[IDW-1:0]);
            grant_id_d = pick_oth[IDW-1:0];
            last_d     = pick_oth[IDW-1:0];
            hold_d     = HOLD_ONE;
          end else begin
            grant_d    = '0;
            grant_id_d = '0;
            hold_d     = '0;
          end
        end else if (hold_q == HOLD_MAX && pick_oth[IDW]) begin
          // The hold budget is used up while another requester waits: rotate.
          grant_d    = onehot(pick_oth[IDW-1:0]);
          grant_id_d = pick_oth[IDW-1:0];
          last_d     = pick_oth[IDW-1:0];
          hold_d     = HOLD_ONE;
          preempt_d  = 1'b1;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        hold_d     = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_req_grant_arbiter.sv
// Self-checking bench for rr_req_grant_arbiter (N=4, MAX_HOLD=8).
// A behavioural model advances at every rising edge and is compared with the
// DUT 1 ns later. Directed sequences check hand-computed literal values at
// falling edges.
module tb_rr_req_grant_arbiter;
  localparam int N     = 4;
  localparam int MH    = 8;
  localparam int IDW   = 2;
  localparam int HCW   = 4;
  localparam int BOUND = (N - 1) * MH + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;
  logic [HCW-1:0] hold_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  rr_req_grant_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_valid(grant_valid),
    .grant_id(grant_id), .preempt(preempt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the first requester at or after last+1 (mod N), skipping excl, or -1.
  function automatic int pick(input logic [N-1:0] r, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  int         m_owner = -1;
  int         m_last  = N - 1;
  int         m_hold  = 0;
  int         m_pre   = 0;
  int         last_hold_seen = 0;
  int         wait_c [N];
  logic [N-1:0] r_s;
  int         oth;
  int         exp_g;

  // The model advances at each rising edge. The outputs and invariants are checked 1 ns later.
  always @(posedge clk) begin
    r_s = req;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_hold = 0; m_pre = 0;
    end else if (m_owner < 0) begin
      m_pre = 0;
      oth = pick(r_s, m_last, -1);
      if (oth >= 0) begin m_owner = oth; m_last = oth; m_hold = 1; end
    end else begin
      m_pre = 0;
      oth = pick(r_s, m_last, m_owner);
      if (!r_s[m_owner]) begin
        if (oth >= 0) begin m_owner = oth; m_last = oth; m_hold = 1; end
        else begin m_owner = -1; m_hold = 0; end
      end else if (m_hold == MH && oth >= 0) begin
        m_owner = oth; m_last = oth; m_hold = 1; m_pre = 1;
      end else if (m_hold < MH) begin
        m_hold = m_hold + 1;
      end
    end
    #1;
    exp_g = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("m_grant", int'(grant), exp_g);
    chk("m_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
    chk("m_id", int'(grant_id), (m_owner < 0) ? 0 : m_owner);
    chk("m_preempt", int'(preempt), m_pre);
    chk("m_hold", int'(hold_cnt), m_hold);
    chk("onehot0", int'($onehot0(grant)), 1);
    chk("grant_past_req", int'((grant & ~r_s) == '0), 1);
    if (preempt) chk("preempt_prev_hold", last_hold_seen, MH);
    for (int i = 0; i < N; i++) begin
      if (!rst && r_s[i] && !grant[i]) wait_c[i]++;
      else wait_c[i] = 0;
      chk("starvation", int'(wait_c[i] <= BOUND), 1);
    end
    last_hold_seen = int'(hold_cnt);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    rst = 1'b1; req = 4'b0000;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_hold", int'(hold_cnt), 0);
    chk("rst_id", int'(grant_id), 0);
    chk("rst_valid", int'(grant_valid), 0);

    // Single requester: the hold count saturates and there is no preemption.
    req = 4'b0001; step();
    chk("single_grant", int'(grant), 1);
    chk("single_hold1", int'(hold_cnt), 1);
    repeat (7) step();
    chk("single_hold8", int'(hold_cnt), 8);
    repeat (2) step();
    chk("single_sat", int'(hold_cnt), 8);
    chk("single_nopre", int'(preempt), 0);
    req = 4'b0000; step();
    chk("single_drop", int'(grant), 0);

    // All four requesters: the grant rotates on hold expiry.
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b1111; step();
    chk("all_g0", int'(grant), 4'b0001);
    repeat (7) step();
    chk("all_g0_hold8", int'(hold_cnt), 8);
    step();
    chk("all_g1", int'(grant), 4'b0010);
    chk("all_pre1", int'(preempt), 1);
    chk("all_hold1", int'(hold_cnt), 1);
    step();
    chk("all_pre_pulse", int'(preempt), 0);
    repeat (7) step();
    chk("all_g2", int'(grant), 4'b0100);
    repeat (8) step();
    chk("all_g3", int'(grant), 4'b1000);
    repeat (8) step();
    chk("all_g0_again", int'(grant), 4'b0001);

    // Handoff when the owner releases.
    rst = 1'b1; req = 4'b0000; step();
    rst = 1'b0; req = 4'b0010; step();
    chk("ho_g1", int'(grant), 4'b0010);
    req = 4'b1010; step(); step();
    chk("ho_hold3", int'(hold_cnt), 3);
    req = 4'b1000; step();
    chk("ho_g3", int'(grant), 4'b1000);
    chk("ho_pre", int'(preempt), 0);
    chk("ho_hold1", int'(hold_cnt), 1);

    // Wrap-around after requester 3 was served.
    req = 4'b0000; step();
    chk("wrap_idle", int'(grant), 0);
    req = 4'b1010; step();
    chk("wrap_g1", int'(grant), 4'b0010);
    chk("wrap_id", int'(grant_id), 1);

    // Reset in the middle of a grant.
    rst = 1'b1; req = 4'b0000; step();
    rst = 1'b0; req = 4'b0100; step();
    chk("mid_g2", int'(grant), 4'b0100);
    repeat (4) step();
    chk("mid_hold5", int'(hold_cnt), 5);
    rst = 1'b1; step();
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_hold", int'(hold_cnt), 0);
    chk("mid_rst_valid", int'(grant_valid), 0);
    rst = 1'b0; req = 4'b0110; step();
    chk("mid_after_g1", int'(grant), 4'b0010);

    // Pseudo-random request patterns, checked against the model only.
    for (int i = 0; i < 60; i++) begin
      req = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) step();
    end
    req = 4'b0000;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
